// File: rtl/capture_ctrl.sv
// capture_ctrl: logic-analyzer capture sequencer (pre-trigger fill, arm, post-trigger fill); optional forced trigger via CAPT_TIMEOUT_EN
module capture_ctrl #(
  parameter int DEPTH         = 512,
  parameter int ADDR_W        = 9,
  parameter int TIMEOUT_SMPLS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              wrt_smpl,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              triggered,
  output logic              armed,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done,
  output logic              timed_out
);
  typedef enum logic [2:0] {IDLE, PRETRIG, ARMED, POSTTRIG, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] tp, smpl_cnt, post_cnt, tp_next;
  logic [ADDR_W:0] pre_target;
  logic capturing, pre_done, trig_hit, force_trig, fire, post_last;
  assign capturing  = state == PRETRIG || state == ARMED || state == POSTTRIG;
  assign we         = wrt_smpl & capturing;
  assign tp_next    = (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
  assign pre_target = (ADDR_W+1)'(DEPTH) - {1'b0, tp};
  assign pre_done   = ({1'b0, smpl_cnt} + (ADDR_W+1)'(1)) == pre_target;
  assign trig_hit   = state == ARMED && armed && triggered;
  assign fire       = trig_hit | force_trig;
  assign post_last  = we && (state == ARMED ? tp == ADDR_W'(1) : post_cnt + ADDR_W'(1) == tp);
`ifdef CAPT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SMPLS + 1);
  logic [TW-1:0] arm_cnt;
  assign force_trig = state == ARMED && we && !trig_hit && arm_cnt == TW'(TIMEOUT_SMPLS - 1);
  // counts armed-state writes and flags a forced trigger until the next start/abort
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      arm_cnt   <= '0;
      timed_out <= 1'b0;
    end else if (abort || start) begin
      arm_cnt   <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == ARMED && we) arm_cnt <= arm_cnt + TW'(1);
      if (force_trig) timed_out <= 1'b1;
    end
`else
  assign force_trig = 1'b0;
  assign timed_out  = 1'b0;
`endif
  // capture sequencer: state, write address, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      armed        <= 1'b0;
      capture_done <= 1'b0;
      waddr        <= '0;
      trig_addr    <= '0;
      tp           <= '0;
      smpl_cnt     <= '0;
      post_cnt     <= '0;
    end else if (abort) begin
      state        <= IDLE;
      armed        <= 1'b0;
      capture_done <= 1'b0;
    end else if (start) begin
      state        <= PRETRIG;
      armed        <= 1'b0;
      capture_done <= 1'b0;
      waddr        <= '0;
      smpl_cnt     <= '0;
      post_cnt     <= '0;
      tp           <= tp_next;
    end else begin
      if (we) waddr <= waddr + ADDR_W'(1);
      case (state)
        PRETRIG:
          if (we) begin
            smpl_cnt <= smpl_cnt + ADDR_W'(1);
            if (pre_done) begin
              state <= ARMED;
              armed <= 1'b1;
            end
          end
        ARMED:
          if (fire) begin
            trig_addr    <= waddr;
            post_cnt     <= {{(ADDR_W-1){1'b0}}, we};
            state        <= post_last ? DONE : POSTTRIG;
            armed        <= !post_last;
            capture_done <= post_last;
          end
        POSTTRIG:
          if (we) begin
            post_cnt <= post_cnt + ADDR_W'(1);
            if (post_last) begin
              state        <= DONE;
              armed        <= 1'b0;
              capture_done <= 1'b1;
            end
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed self-checking bench for capture_ctrl with a completion scoreboard
module tb_capture_ctrl;
  localparam int AW = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, wrt_smpl = 1'b0, triggered = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic armed, we, capture_done, timed_out;
  logic [AW-1:0] waddr, trig_addr;
  int n_cmp = 0, n_err = 0;
  typedef struct {logic [AW-1:0] ta; logic [AW-1:0] wa; int cyc;} exp_t;
  exp_t sb[$];

  capture_ctrl #(.DEPTH(16), .ADDR_W(AW), .TIMEOUT_SMPLS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .wrt_smpl(wrt_smpl),
    .trig_pos(trig_pos), .triggered(triggered), .armed(armed), .we(we), .waddr(waddr),
    .trig_addr(trig_addr), .capture_done(capture_done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [AW-1:0] ta, logic [AW-1:0] wa, int cyc);
    exp_t e;
    e.ta = ta;
    e.wa = wa;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(string tag, int budget);
    int n = 0;
    exp_t e;
    while (!capture_done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, capture_done, 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_cycles"}, n, e.cyc);
    check({tag, "_trig_addr"}, trig_addr, e.ta);
    check({tag, "_waddr"}, waddr, e.wa);
    check({tag, "_armed"}, armed, 0);
    check({tag, "_we"}, we, 0);
  endtask

  initial begin
    int n;
    #12;
    check("rst_armed", armed, 0);
    check("rst_done", capture_done, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_waddr", waddr, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_we", we, 0);
    rst_n = 1'b1;
    tick();

    // 1: continuous writes, trigger after wrap at waddr 5
    trig_pos = 4; wrt_smpl = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 11; i++) tick();
    check("t1_armed_early", armed, 0);
    tick();
    check("t1_armed_rise", armed, 1);
    check("t1_waddr_armed", waddr, 12);
    n = 0;
    while (waddr != 5 && n < 40) begin
      tick();
      n++;
    end
    check("t1_reach_5", n, 9);
    triggered = 1;
    tick();
    triggered = 0;
    check("t1_trig_addr", trig_addr, 5);
    tick(); tick();
    check("t1_not_done", capture_done, 0);
    push(5, 9, 1);
    wait_done("t1", 5);
    check("t1_timed_out", timed_out, 0);

    // 2: triggered held from start; accepted on first armed cycle
    triggered = 1; start = 1;
    tick();
    start = 0;
    push(12, 0, 16);
    wait_done("t2", 30);
    triggered = 0;

    // 3: toggling strobe, trig_pos 0 treated as 1
    trig_pos = 0; wrt_smpl = 0; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) check("t3_armed_early", armed, 0);
      wrt_smpl = 1; tick();
      wrt_smpl = 0; tick();
    end
    check("t3_armed", armed, 1);
    check("t3_waddr_armed", waddr, 15);
    triggered = 1;
    tick();
    triggered = 0;
    check("t3_no_done_yet", capture_done, 0);
    check("t3_trig_addr_next", trig_addr, 15);
    wrt_smpl = 1;
    tick();
    push(15, 0, 0);
    wait_done("t3", 0);

    // 4: abort after two of four post writes, simultaneous start ignored
    trig_pos = 4; triggered = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 14; i++) tick();
    check("t4_waddr_mid", waddr, 14);
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0; triggered = 0;
    check("t4_we_after_abort", we, 0);
    check("t4_armed", armed, 0);
    check("t4_trig_addr", trig_addr, 12);
    tick();
    check("t4_waddr_hold", waddr, 14);
    check("t4_done", capture_done, 0);
    check("t4_we_idle", we, 0);

    // 5: asynchronous reset while armed
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 15; i++) tick();
    check("t5_armed_before", armed, 1);
    #2 rst_n = 0;
    #1;
    check("t5_armed_async", armed, 0);
    check("t5_waddr", waddr, 0);
    check("t5_trig_addr", trig_addr, 0);
    check("t5_we", we, 0);
    check("t5_done", capture_done, 0);
    #1 rst_n = 1;
    tick();

    // 6: no trigger at all
    start = 1;
    tick();
    start = 0;
`ifdef CAPT_TIMEOUT_EN
    push(3, 7, 23);
    wait_done("t6", 40);
    check("t6_timed_out", timed_out, 1);
    start = 1;
    tick();
    start = 0;
    check("t6_timed_out_clr", timed_out, 0);
`else
    for (int i = 0; i < 112; i++) tick();
    check("t6_armed", armed, 1);
    check("t6_done", capture_done, 0);
    check("t6_timed_out", timed_out, 0);
    check("t6_waddr", waddr, 0);
`endif
    abort = 1;
    tick();
    abort = 0;
    check("t6_abort_armed", armed, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
